extmem_rdbuf: RTL and testbench

EXTMEM_RDBUF -- requirements
Module: extmem_rdbuf

---
 rtl/extmem_pkg.sv | 18 +
 rtl/sync_fifo.sv | 77 +++++++
 rtl/extmem_rdbuf.sv | 110 +++++++++++
 tb/tb_extmem_rdbuf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/extmem_pkg.sv
// Shared constants and the pixel word layout for the external-memory read buffer.
// Latency and backpressure are defined by the blocks that import this package.
package extmem_pkg;

   localparam logic [15:0] MAX_PIXADDR = 16'hFFFF;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_DEPTH   = 16;
   localparam int DEF_HOLD_HI = 12;
   localparam int DEF_HOLD_LO = 4;

   // Buffered word: start-of-frame tag in the MSB above the pixel data.
   typedef struct packed {
      logic                  sof;
      logic [DEF_DATA_W-1:0] data;
   } pix_word_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head visible 1 cycle after a push into an empty FIFO.
// Push while full is dropped (push_drop) unless a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk_out,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic                     pop,
   output logic                     rd_vld,
   output logic [WIDTH-1:0]         rd_dat,
   output logic [$clog2(DEPTH):0]   level,
   output logic [$clog2(DEPTH):0]   level_nxt,
   output logic                     push_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             empty, full, do_push, do_pop;

   always_comb begin
      empty    = (level_q == '0);
      full     = (level_q == LW'(DEPTH));
      do_pop   = pop & ~empty;
      // A pop on the same edge frees the slot the push writes into.
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = wr_dat;
   end

   always_ff @(posedge clk_out) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Head is forced to zero while empty so nothing stale leaks out, including during reset.
   always_comb begin
      rd_vld    = ~empty;
      rd_dat    = empty ? '0 : mem_q[rd_ptr_q];
      level     = level_q;
      level_nxt = level_d;
      push_drop = push & full & ~do_pop;
   end

endmodule

// File: rtl/extmem_rdbuf.sv
// Captures external RAM read data into a FWFT pixel FIFO; head valid 1 cycle after capture.
// hold back-pressures the memory controller with HOLD_HI/HOLD_LO hysteresis; optional EXTMEM_RDBUF_OVF_EN adds a sticky overflow flag.
module extmem_rdbuf
   import extmem_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int HOLD_HI = DEF_HOLD_HI,
   parameter int HOLD_LO = DEF_HOLD_LO
) (
   input  logic                    clk_out,
   input  logic                    reset_n,
   input  logic                    rwn,
   input  logic                    ce_n,
   input  logic                    oe_n,
   input  logic [15:0]             addr,
   input  logic [DATA_W-1:0]       dq_in,
   output logic                    hold,
   output logic [DATA_W-1:0]       pix_data,
   output logic                    pix_sof,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic                    frame_done,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    ovf,
   input  logic                    ovf_clr
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic              cap;
   logic [DATA_W:0]   wr_word;
   logic [DATA_W:0]   rd_word;
   logic              rd_vld;
   logic [LW-1:0]     level, level_nxt;
   logic              push_drop;
   logic              hold_q, hold_d;
   logic              frame_done_q, frame_done_d;

   // oe_n is low for exactly one rising edge per read, so no edge detect is needed.
   always_comb begin
      cap     = rwn & ~ce_n & ~oe_n & ~hold_q;
      wr_word = {(addr == 16'h0000), dq_in};
   end

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_out   (clk_out),
      .reset_n   (reset_n),
      .push      (cap),
      .wr_dat    (wr_word),
      .pop       (pix_ready),
      .rd_vld    (rd_vld),
      .rd_dat    (rd_word),
      .level     (level),
      .level_nxt (level_nxt),
      .push_drop (push_drop)
   );

   // Hysteresis is evaluated on the post-edge level so hold lands on the same edge.
   always_comb begin
      hold_d = hold_q;
      if (int'(level_nxt) >= HOLD_HI)      hold_d = 1'b1;
      else if (int'(level_nxt) <= HOLD_LO) hold_d = 1'b0;
      frame_done_d = cap & (addr == MAX_PIXADDR);
   end

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         hold_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef EXTMEM_RDBUF_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr)   ovf_d = 1'b0;
      if (push_drop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_clr ^ push_drop;
   assign ovf        = 1'b0;
`endif

   always_comb begin
      hold       = hold_q;
      pix_valid  = rd_vld;
      pix_sof    = rd_word[DATA_W];
      pix_data   = rd_word[DATA_W-1:0];
      frame_done = frame_done_q;
      fifo_level = level;
   end

endmodule

// File: tb/tb_extmem_rdbuf.sv
// Bench for extmem_rdbuf: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the buffer.
module tb_extmem_rdbuf;
   import extmem_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int HI    = 12;
   localparam int LO    = 4;
   localparam int LW    = 5;
`ifdef EXTMEM_RDBUF_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic          clk_out = 1'b0;
   logic          reset_n, rwn, ce_n, oe_n, pix_ready, ovf_clr;
   logic [15:0]   addr;
   logic [DW-1:0] dq_in;
   logic          hold, pix_sof, pix_valid, frame_done, ovf;
   logic [DW-1:0] pix_data;
   logic [LW-1:0] fifo_level;
   logic          hold2, pix_sof2, pix_valid2, frame_done2, ovf2;
   logic [DW-1:0] pix_data2;
   logic [LW-1:0] fifo_level2;

   extmem_rdbuf #(.DATA_W(DW), .DEPTH(DEPTH), .HOLD_HI(HI), .HOLD_LO(LO)) dut (
      .clk_out(clk_out), .reset_n(reset_n), .rwn(rwn), .ce_n(ce_n), .oe_n(oe_n),
      .addr(addr), .dq_in(dq_in), .hold(hold), .pix_data(pix_data), .pix_sof(pix_sof),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
      .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr));

   // Hold threshold above DEPTH so this instance can be driven into the full state.
   extmem_rdbuf #(.DATA_W(DW), .DEPTH(DEPTH), .HOLD_HI(DEPTH + 1), .HOLD_LO(LO)) dut_nh (
      .clk_out(clk_out), .reset_n(reset_n), .rwn(rwn), .ce_n(ce_n), .oe_n(oe_n),
      .addr(addr), .dq_in(dq_in), .hold(hold2), .pix_data(pix_data2), .pix_sof(pix_sof2),
      .pix_valid(pix_valid2), .pix_ready(pix_ready), .frame_done(frame_done2),
      .fifo_level(fifo_level2), .ovf(ovf2), .ovf_clr(ovf_clr));

   always #5 clk_out = ~clk_out;

   pix_word_t q[$];
   bit        hold_m, fd_m, ovf_m;
   int        n_vec = 0;
   int        n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("valid", pix_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("data", pix_data, q[0].data);
         chk("sof", pix_sof, q[0].sof);
      end else begin
         chk("data_empty", pix_data, 0);
         chk("sof_empty", pix_sof, 0);
      end
      chk("level", fifo_level, q.size());
      chk("hold", hold, hold_m);
      chk("frame_done", frame_done, fd_m);
      chk("ovf", ovf, ovf_m);
   endtask

   // Advance one clock: update the model from the current inputs, then compare after the edge.
   task automatic step();
      bit        cap, drop;
      pix_word_t w;
      cap  = (rwn == 1'b1) && (ce_n == 1'b0) && (oe_n == 1'b0) && !hold_m;
      drop = 1'b0;
      if (q.size() > 0 && pix_ready == 1'b1) void'(q.pop_front());
      if (cap) begin
         w.sof  = (addr == 16'h0000);
         w.data = dq_in;
         if (q.size() < DEPTH) q.push_back(w);
         else drop = 1'b1;
      end
      if (q.size() >= HI)      hold_m = 1'b1;
      else if (q.size() <= LO) hold_m = 1'b0;
      fd_m = cap && (addr == 16'hFFFF);
      if (drop)                 ovf_m = OVF_ON;
      else if (ovf_clr == 1'b1) ovf_m = 1'b0;
      @(posedge clk_out);
      #1;
      chk_model();
   endtask

   task automatic idle_inputs();
      rwn = 1'b1; ce_n = 1'b1; oe_n = 1'b1; pix_ready = 1'b0; ovf_clr = 1'b0;
      addr = 16'h0001; dq_in = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q.delete();
      hold_m = 1'b0; fd_m = 1'b0; ovf_m = 1'b0;
      #2;
      chk("rst_level", fifo_level, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_hold", hold, 0);
      chk("rst_data", pix_data, 0);
      chk("rst_sof", pix_sof, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_ovf", ovf, 0);
      @(posedge clk_out);
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic        rwn, ce_n, oe_n;
      logic [15:0] addr;
      logic [7:0]  dq;
      logic        rdy;
      logic        e_vld;
      logic [7:0]  e_dat;
      logic        e_sof;
      int          e_lvl;
      logic        e_fd;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int       maxlvl;
      bit       seen12;
      int       got_n;
      logic [7:0] got [$];
      bit       got_sof [$];

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0, 1, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0, 1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h55, 1'b0, 1'b1, 8'hAA, 1'b0, 1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0005, 8'h44, 1'b0, 1'b1, 8'h33, 1'b1, 2, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 16'h0005, 8'h44, 1'b1, 1'b1, 8'h44, 1'b0, 1, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 16'h0005, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};

      idle_inputs();
      reset_n = 1'b1;
      #3;
      do_reset();

      // Vector table
      for (int i = 0; i < 13; i++) begin
         rwn = tbl[i].rwn; ce_n = tbl[i].ce_n; oe_n = tbl[i].oe_n;
         addr = tbl[i].addr; dq_in = tbl[i].dq; pix_ready = tbl[i].rdy;
         step();
         chk($sformatf("tbl%0d_vld", i), pix_valid, tbl[i].e_vld);
         chk($sformatf("tbl%0d_dat", i), pix_data, tbl[i].e_dat);
         chk($sformatf("tbl%0d_sof", i), pix_sof, tbl[i].e_sof);
         chk($sformatf("tbl%0d_lvl", i), fifo_level, tbl[i].e_lvl);
         chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].e_fd);
         chk($sformatf("tbl%0d_hold", i), hold, 0);
      end

      // Streaming read pass addr 0..7 with downstream always ready
      idle_inputs();
      do_reset();
      ce_n = 1'b0; pix_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         oe_n  = (i % 2 == 1) || (i >= 16);
         addr  = 16'(i / 2);
         dq_in = 8'(i / 2) + 8'h10;
         step();
         chk("stream_hold", hold, 0);
         if (pix_valid) begin
            got.push_back(pix_data);
            got_sof.push_back(pix_sof);
         end
      end
      got_n = got.size();
      chk("stream_count", got_n, 8);
      for (int i = 0; i < got_n && i < 8; i++) begin
         chk($sformatf("stream_pix%0d", i), got[i], 8'h10 + 8'(i));
         chk($sformatf("stream_sof%0d", i), got_sof[i], i == 0);
      end

      // Fill with downstream stalled until hold stops the captures
      idle_inputs();
      do_reset();
      ce_n = 1'b0;
      maxlvl = 0; seen12 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         oe_n  = (i % 2 == 1);
         addr  = 16'(i + 1);
         dq_in = 8'(i);
         step();
         if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
         if (fifo_level == 12 && !seen12) begin
            seen12 = 1'b1;
            chk("hold_rise_at_12", hold, 1);
         end
      end
      chk("hold_max_level", maxlvl, 12);
      oe_n = 1'b1; pix_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("hyst_level9", fifo_level, 9);
      chk("hyst_hold", hold, 1);
      pix_ready = 1'b0;
      do_reset();

      // Refill, then drain and check hold release at level 4
      ce_n = 1'b0;
      for (int i = 0; i < 30; i++) begin
         oe_n = (i % 2 == 1); addr = 16'(i + 1); dq_in = 8'(i + 100);
         step();
      end
      chk("refill_hold", hold, 1);
      oe_n = 1'b1; pix_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         if (fifo_level == 5) chk("drain_hold_at5", hold, 1);
         if (fifo_level == 4) chk("drain_hold_at4", hold, 0);
      end
      chk("drain_empty", fifo_level, 0);

      // Overflow on the no-hold instance
      idle_inputs();
      do_reset();
      ce_n = 1'b0; oe_n = 1'b0;
      for (int i = 0; i < 19; i++) begin
         addr = 16'(i + 1); dq_in = 8'(i);
         step();
      end
      chk("full_level", fifo_level2, 16);
      chk("full_head", pix_data2, 8'h00);
      chk("full_ovf", ovf2, OVF_ON);
      ovf_clr = 1'b1;
      step();
      chk("ovf_set_wins", ovf2, OVF_ON);
      oe_n = 1'b1;
      step();
      chk("ovf_cleared", ovf2, 0);
      ovf_clr = 1'b0; oe_n = 1'b0; pix_ready = 1'b1; dq_in = 8'hEE;
      step();
      chk("full_pushpop_level", fifo_level2, 16);
      chk("full_pushpop_head", pix_data2, 8'h01);
      chk("full_pushpop_ovf", ovf2, 0);

      // Random traffic
      idle_inputs();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         int r;
         rwn  = ($urandom % 8) != 0;
         ce_n = ($urandom % 8) == 0;
         oe_n = $urandom % 2;
         r = $urandom % 8;
         if (r == 0)      addr = 16'h0000;
         else if (r == 1) addr = 16'hFFFF;
         else             addr = 16'($urandom);
         dq_in = 8'($urandom);
         if ((i / 150) % 2 == 1) pix_ready = ($urandom % 4) == 0;
         else                    pix_ready = ($urandom % 4) != 0;
         ovf_clr = ($urandom % 16) == 0;
         if ($urandom % 500 == 0) do_reset();
         else step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
